// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the I/D main-memory arbiter.
package memory_arbiter_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 28;
  localparam int DEFAULT_DATA_WIDTH = 128;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_I = 3'd1,
    SERVE_D = 3'd2,
    DONE_I  = 3'd3,
    DONE_D  = 3'd4
  } state_e;

endpackage

// File: rtl/memory_arbiter.sv
// Two-requester (I-cache / D-cache) arbiter onto one block-wide memory port.
// Optional MEM_ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  I_READ,
  input  logic [ADDR_WIDTH-1:0] I_ADDRESS,
  output logic [DATA_WIDTH-1:0] I_READDATA,
  output logic                  I_BUSYWAIT,
  input  logic                  D_READ,
  input  logic                  D_WRITE,
  input  logic [ADDR_WIDTH-1:0] D_ADDRESS,
  input  logic [DATA_WIDTH-1:0] D_WRITEDATA,
  output logic [DATA_WIDTH-1:0] D_READDATA,
  output logic                  D_BUSYWAIT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDRESS,
  output logic [DATA_WIDTH-1:0] MEM_WRITEDATA,
  input  logic [DATA_WIDTH-1:0] MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
);

  state_e                  state_q, state_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0]   d_rdata_q, d_rdata_d;
  logic                    seen_busy_q, seen_busy_d;
  logic                    grant_d_side, grant_i_side;
  logic                    d_req, i_req, serving;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic                    last_grant_q, last_grant_d;
`endif

  assign d_req = D_READ | D_WRITE;
  assign i_req = I_READ;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // On a tie, D wins only if I was granted last.
  assign grant_d_side = d_req && (!i_req || (last_grant_q == REQ_I));
`else
  assign grant_d_side = d_req;
`endif
  assign grant_i_side = i_req && !grant_d_side;

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    seen_busy_d = seen_busy_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_d_side) begin
          state_d = SERVE_D;
          write_d = D_WRITE;
          addr_d  = D_ADDRESS;
          wdata_d = D_WRITEDATA;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_d = REQ_D;
`endif
        end else if (grant_i_side) begin
          state_d = SERVE_I;
          write_d = 1'b0;
          addr_d  = I_ADDRESS;
          wdata_d = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_d = REQ_I;
`endif
        end
      end
      SERVE_I, SERVE_D: begin
        // Completion needs a busy phase first, then the first idle edge.
        if (!seen_busy_q) begin
          seen_busy_d = MEM_BUSYWAIT;
        end else if (!MEM_BUSYWAIT) begin
          seen_busy_d = 1'b0;
          if (state_q == SERVE_I) begin
            state_d   = DONE_I;
            i_rdata_d = MEM_READDATA;
          end else begin
            state_d = DONE_D;
            if (!write_q) begin
              d_rdata_d = MEM_READDATA;
            end
          end
        end
      end
      DONE_I, DONE_D: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      seen_busy_q <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= REQ_I;
`endif
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      seen_busy_q <= seen_busy_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign serving       = (state_q == SERVE_I) || (state_q == SERVE_D);
  assign MEM_READ      = serving && !write_q;
  assign MEM_WRITE     = serving && write_q;
  assign MEM_ADDRESS   = addr_q;
  assign MEM_WRITEDATA = wdata_q;

  assign I_READDATA = i_rdata_q;
  assign D_READDATA = d_rdata_q;
  // Busywait is combinational so a cache stalls in the cycle it requests.
  assign I_BUSYWAIT = !RESET && i_req && (state_q != DONE_I);
  assign D_BUSYWAIT = !RESET && d_req && (state_q != DONE_D);

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares one block-wide main memory port between the instruction-cache side (I) and the data-cache side (D) of the RV32IM core.
- Each requester sees a private READ/WRITE/ADDRESS/WRITEDATA/READDATA/BUSYWAIT interface, identical to the existing instruction_memory/data_memory ports, so caches connect unchanged.
- Arbitrates, latches the granted request, sequences one downstream block transfer, and returns read data to the winner.

Parameters:
- ADDR_WIDTH, 28, block address width.
- DATA_WIDTH, 128, block (4-word) data width.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- I_READ  in  1  instruction-side block read request.
- I_ADDRESS  in  ADDR_WIDTH  instruction block address.
- I_READDATA  out  DATA_WIDTH  instruction block returned.
- I_BUSYWAIT  out  1  instruction side must hold its request.
- D_READ  in  1  data-side block read request.
- D_WRITE  in  1  data-side block write (write-back) request.
- D_ADDRESS  in  ADDR_WIDTH  data block address.
- D_WRITEDATA  in  DATA_WIDTH  block to write.
- D_READDATA  out  DATA_WIDTH  data block returned.
- D_BUSYWAIT  out  1  data side must hold its request.
- MEM_READ  out  1  downstream read strobe.
- MEM_WRITE  out  1  downstream write strobe.
- MEM_ADDRESS  out  ADDR_WIDTH  downstream block address.
- MEM_WRITEDATA  out  DATA_WIDTH  downstream write block.
- MEM_READDATA  in  DATA_WIDTH  downstream read block.
- MEM_BUSYWAIT  in  1  downstream access in progress.

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; latched address/data/readdata=0; seen_busy=0; any in-flight downstream access abandoned.
- States: IDLE, SERVE_I, SERVE_D, DONE_I, DONE_D.
- IDLE: if D_READ|D_WRITE -> SERVE_D; else if I_READ -> SERVE_I. Fixed priority D over I. On the transition edge, latch the winner's op, address and writedata.
- SERVE_x: MEM_READ/MEM_WRITE/MEM_ADDRESS/MEM_WRITEDATA are driven from the latched registers only. Requester input changes during SERVE are ignored.
- seen_busy sets on the first edge with MEM_BUSYWAIT=1.
- Completion is the first edge with seen_busy=1 and MEM_BUSYWAIT=0. On that edge:
  - a read latches MEM_READDATA into x_READDATA;
  - state goes to DONE_x and seen_busy clears.
- DONE_x: lasts exactly 1 cycle. MEM strobes are 0, x_BUSYWAIT=0, and x_READDATA is valid. Next state is IDLE, and the arbiter re-arbitrates there.
- Latency: a request arriving in IDLE with memory busy for N cycles completes in 1+N+1 cycles; a request losing arbitration waits one full transaction in addition.
- x_BUSYWAIT = (request asserted) && !(state==DONE_x); combinational, so it rises in the same cycle the request does.
- x_READDATA holds its last value until the next read completion on that side; a write does not alter D_READDATA.
- D_READ and D_WRITE both high is illegal. The arbiter forwards WRITE only and does not set D_READDATA.
- Requests deasserted while in SERVE do not abort the transfer. The transfer finishes and DONE is still entered.
- Downstream strobes are never asserted in IDLE or DONE, which guarantees one dead cycle between transactions.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last_grant register, reset to I. On simultaneous I and D requests in IDLE, the side not granted last wins; a single requester always wins. last_grant updates on entry to SERVE_x.
- Undefined: fixed D-over-I priority as above, with no extra state.

Decomposition:
- Package memory_arbiter_pkg holds:
  - the state enum (IDLE, SERVE_I, SERVE_D, DONE_I, DONE_D);
  - requester ID constants REQ_I=0, REQ_D=1;
  - default widths 28/128.
- No sub-module; single flat FSM plus latch registers.

Test Plan:
- Reset mid-SERVE_D (RESET high during MEM_BUSYWAIT=1) -> same cycle MEM_WRITE=0, D_BUSYWAIT=0, D_READDATA=0, and state is IDLE after release.
- I_READ alone, I_ADDRESS=28'h0000010, memory returns 128'hDEAD_BEEF_0000_0001_0000_0002_0000_0003 after 5 busy cycles -> MEM_READ high for 6 cycles, I_READDATA equals that value, I_BUSYWAIT low exactly 7 cycles after the request.
- D_WRITE, D_ADDRESS=28'h0000020, D_WRITEDATA=128'h1111…1111 -> MEM_WRITE=1 with the same address/data throughout; D_READDATA unchanged; D_BUSYWAIT drops after completion.
- I_READ and D_READ raised in the same cycle -> D served first; I_BUSYWAIT stays high until I completes after one dead cycle. With MEM_ARB_ROUND_ROBIN_EN, the second simultaneous pair grants I first.
- D_ADDRESS changed from 28'h30 to 28'h40 mid-SERVE_D -> MEM_ADDRESS stays 28'h30 to completion.
- D_READ and D_WRITE both high -> only MEM_WRITE asserted; MEM_READ stays 0.
